// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle FSM sequencing SimpleARM instructions
module mc_control_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int ALUC_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic              IsMul,
    input  logic              CondEx,
    input  logic              MemReady,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic              PCWrite,
    output logic              RegW,
    output logic              MemW,
    output logic              MemReq,
    output logic              LinkW,
    output logic              MulStart,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [3:0]        FlagW,
    output logic              Busy
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_MULT, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(4);
    localparam logic [3:0]        MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state, next;
    logic [3:0] mul_cnt;
    logic       mul_op;
    logic [3:0] dp_cmd;
    logic       is_cmp, is_tst, rd_pc;

    assign dp_cmd = Funct[4:1];
    assign is_cmp = (dp_cmd == 4'hA) || (dp_cmd == 4'hB);
    assign is_tst = (dp_cmd == 4'h8) || (dp_cmd == 4'h9);
    assign rd_pc  = (Rd == 4'hF);

    // mul_op remembers that ALUWB was reached through MULT, so it selects MulResult
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            mul_cnt <= 4'd0;
            mul_op  <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE)
                mul_op <= (next == S_MULT);
            if (state == S_DECODE && next == S_MULT)
                mul_cnt <= MUL_LOAD;
            else if (state == S_MULT && mul_cnt != 4'd0)
                mul_cnt <= mul_cnt - 4'd1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Op == 2'b01)     next = S_MEMADR;
                else if (Op == 2'b00)
                    next = IsMul ? S_MULT : (Funct[5] ? S_EXEC_I : S_EXEC_R);
                else                 next = S_BRANCH;
            end
            S_MEMADR: next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next = S_FETCH;
            S_MEMWR:  next = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC_R: next = S_ALUWB;
            S_EXEC_I: next = S_ALUWB;
            S_MULT:   next = (mul_cnt == 4'd0) ? S_ALUWB : S_MULT;
            S_ALUWB:  next = S_FETCH;
            S_BRANCH: next = S_FETCH;
            default:  next = S_FETCH;
        endcase
    end

    always_comb begin
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        PCWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        MemReq     = 1'b0;
        LinkW      = 1'b0;
        MulStart   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        FlagW      = 4'b0000;
        Busy       = (state != S_FETCH);
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        if (state != S_FETCH) begin
            ImmSrc = Op[1] ? 2'b10 : Op;
            RegSrc = {(Op == 2'b01) && !Funct[0], Op[1]};
        end
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // fetch strobes stay low while reset is held so no write escapes it
                IRWrite   = MemReady && !reset;
                PCWrite   = MemReady && !reset;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = CondEx && !rd_pc;
                PCWrite   = CondEx && rd_pc;
            end
            S_MEMWR: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                MemW   = CondEx;
            end
            S_EXEC_R, S_EXEC_I: begin
                ALUSrcB    = (state == S_EXEC_I) ? 2'b01 : 2'b00;
                ALUControl = ALUC_W'(dp_cmd);
                if (CondEx) begin
                    if (is_cmp)      FlagW = 4'b1111;
                    else if (is_tst) FlagW = 4'b1110;
                    else             FlagW = {{3{Funct[0]}}, 1'b0};
                end
            end
            S_MULT: MulStart = (mul_cnt == MUL_LOAD);
            S_ALUWB: begin
                ResultSrc = mul_op ? 2'b11 : 2'b00;
                if (mul_op || !(is_cmp || is_tst)) begin
                    RegW    = CondEx && !rd_pc;
                    PCWrite = CondEx && rd_pc;
                end
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = CondEx;
                LinkW     = CondEx && (Op == 2'b11);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized cycle-accurate check of mc_control_unit
module tb_mc_control_unit;

    localparam int MULN = 4;
    localparam int K_DPR = 0, K_DPI = 1, K_LDR = 2, K_STR = 3, K_B = 4, K_BL = 5, K_MUL = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IsMul, CondEx, MemReady;
    logic       IRWrite, AdrSrc, PCWrite, RegW, MemW, MemReq, LinkW, MulStart;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] ALUControl, FlagW;
    logic       Busy;

    mc_control_unit #(.MUL_CYCLES(MULN), .ALUC_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
        .CondEx(CondEx), .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .PCWrite(PCWrite), .RegW(RegW), .MemW(MemW), .MemReq(MemReq), .LinkW(LinkW),
        .MulStart(MulStart), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw, adrsrc, pcw, regw, memw, memreq, linkw, mulstart;
        logic [1:0] srca, srcb, res, imm, regsrc;
        logic [3:0] aluc, flagw;
        logic       busy;
    } obs_t;

    obs_t  eq[$];
    logic  mq[$];
    string tq[$];
    int    checks = 0, errors = 0;
    int    instr_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t observed();
        obs_t o;
        o = {IRWrite, AdrSrc, PCWrite, RegW, MemW, MemReq, LinkW, MulStart,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, Busy};
        return o;
    endfunction

    function automatic obs_t quiet(input logic busy, input logic [1:0] imm, input logic [1:0] rs);
        obs_t e;
        e        = '0;
        e.aluc   = 4'd4;
        e.busy   = busy;
        e.imm    = busy ? imm : 2'b00;
        e.regsrc = busy ? rs : 2'b00;
        return e;
    endfunction

    function automatic void push(input obs_t e, input logic mr, input string t);
        eq.push_back(e);
        mq.push_back(mr);
        tq.push_back(t);
    endfunction

    // Expected per-cycle outputs straight from the instruction's phase list
    function automatic void build(input int kind, input logic [5:0] f, input logic [3:0] rd,
                                  input logic c, input int fw, input int mw);
        obs_t e;
        logic [1:0] imm, rs;
        logic [3:0] cmd;
        logic is_test, pc_dst;
        eq.delete(); mq.delete(); tq.delete();
        cmd = f[4:1];
        is_test = (cmd >= 4'h8) && (cmd <= 4'hB);
        pc_dst = (rd == 4'd15);
        case (kind)
            K_LDR:      begin imm = 2'b01; rs = 2'b00; end
            K_STR:      begin imm = 2'b01; rs = 2'b10; end
            K_B, K_BL:  begin imm = 2'b10; rs = 2'b01; end
            default:    begin imm = 2'b00; rs = 2'b00; end
        endcase
        for (int i = 0; i <= fw; i++) begin
            e = quiet(1'b0, imm, rs);
            e.memreq = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
            e.irw = (i == fw); e.pcw = (i == fw);
            push(e, i == fw, "fetch");
        end
        e = quiet(1'b1, imm, rs);
        e.srca = 2'b01; e.srcb = 2'b10;
        push(e, 1'($urandom_range(0, 1)), "decode");
        case (kind)
            K_DPR, K_DPI: begin
                e = quiet(1'b1, imm, rs);
                e.srcb = (kind == K_DPI) ? 2'b01 : 2'b00;
                e.aluc = cmd;
                if (c) begin
                    if (cmd == 4'hA || cmd == 4'hB)      e.flagw = 4'b1111;
                    else if (cmd == 4'h8 || cmd == 4'h9) e.flagw = 4'b1110;
                    else                                 e.flagw = f[0] ? 4'b1110 : 4'b0000;
                end
                push(e, 1'($urandom_range(0, 1)), "exec");
                e = quiet(1'b1, imm, rs);
                if (!is_test) begin e.regw = c && !pc_dst; e.pcw = c && pc_dst; end
                push(e, 1'($urandom_range(0, 1)), "aluwb");
            end
            K_LDR, K_STR: begin
                e = quiet(1'b1, imm, rs);
                e.srcb = 2'b01;
                push(e, 1'($urandom_range(0, 1)), "memadr");
                for (int i = 0; i <= mw; i++) begin
                    e = quiet(1'b1, imm, rs);
                    e.memreq = 1; e.adrsrc = 1;
                    if (kind == K_STR) e.memw = c;
                    push(e, i == mw, (kind == K_LDR) ? "memrd" : "memwr");
                end
                if (kind == K_LDR) begin
                    e = quiet(1'b1, imm, rs);
                    e.res = 2'b01; e.regw = c && !pc_dst; e.pcw = c && pc_dst;
                    push(e, 1'($urandom_range(0, 1)), "memwb");
                end
            end
            K_B, K_BL: begin
                e = quiet(1'b1, imm, rs);
                e.srca = 2'b10; e.srcb = 2'b01; e.res = 2'b10;
                e.pcw = c; e.linkw = c && (kind == K_BL);
                push(e, 1'($urandom_range(0, 1)), "branch");
            end
            default: begin
                for (int i = 0; i < MULN; i++) begin
                    e = quiet(1'b1, imm, rs);
                    e.mulstart = (i == 0);
                    push(e, 1'($urandom_range(0, 1)), "mult");
                end
                e = quiet(1'b1, imm, rs);
                e.res = 2'b11; e.regw = c && !pc_dst; e.pcw = c && pc_dst;
                push(e, 1'($urandom_range(0, 1)), "aluwb");
            end
        endcase
    endfunction

    // Called at posedge+1 of the instruction's first FETCH cycle; returns at the next one
    task automatic run(input int kind, input logic [5:0] f, input logic [3:0] rd,
                       input logic c, input int fw, input int mw, input int abort_at);
        obs_t o;
        build(kind, f, rd, c, fw, mw);
        instr_no++;
        Op    = (kind == K_LDR || kind == K_STR) ? 2'b01 :
                (kind == K_B) ? 2'b10 : (kind == K_BL) ? 2'b11 : 2'b00;
        Funct = f; Rd = rd; CondEx = c; IsMul = (kind == K_MUL);
        for (int i = 0; i < eq.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            MemReady = mq[i];
            @(negedge clk);
            o = observed();
            check($sformatf("%s@%0d/i%0d", tq[i], i, instr_no), 32'(o), 32'(eq[i]));
            if (i == abort_at) begin
                MemReady = 1'b1;
                reset = 1'b1;
                #1;
                check("rst_async_strobes", {Busy, IRWrite, PCWrite, RegW, MemW, LinkW, MulStart},
                      7'b0);
                check("rst_async_memreq", MemReq, 1'b1);
                @(posedge clk); #1;
                check("rst_edge_state", {Busy, RegW, MemW}, 3'b0);
                reset = 1'b0;
                MemReady = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        obs_t e;
        int kind, fw, mw;
        logic [5:0] f;
        logic [3:0] rd;
        reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        IsMul = 1'b0; CondEx = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = quiet(1'b0, 2'b00, 2'b00);
        e.memreq = 1; e.srca = 2'b01; e.srcb = 2'b10; e.res = 2'b10;
        check("reset_outputs", 32'(observed()), 32'(e));
        @(posedge clk); #1;
        reset = 1'b0;

        run(K_DPI, 6'b101001, 4'd1, 1'b1, 0, 0, -1);
        run(K_DPR, 6'b010101, 4'd3, 1'b1, 0, 0, -1);
        run(K_LDR, 6'b011001, 4'd2, 1'b1, 0, 3, -1);
        run(K_STR, 6'b011000, 4'd5, 1'b0, 0, 0, -1);
        run(K_BL,  6'b000000, 4'd0, 1'b1, 0, 0, -1);
        run(K_MUL, 6'b000000, 4'd7, 1'b1, 0, 0, -1);
        run(K_MUL, 6'b000001, 4'd7, 1'b1, 0, 0, 3);

        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 6);
            f    = 6'($urandom);
            rd   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            case (kind)
                K_DPR: f[5] = 1'b0;
                K_DPI: f[5] = 1'b1;
                K_LDR: f[0] = 1'b1;
                K_STR: f[0] = 1'b0;
                K_MUL: f = {5'b0, f[0]};
                default: ;
            endcase
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            run(kind, f, rd, 1'($urandom_range(0, 3) != 0), fw, mw,
                (kind == K_MUL && $urandom_range(0, 7) == 0) ? 2 + fw + $urandom_range(0, MULN - 1) : -1);
        end

        MemReady = 1'b0;
        @(negedge clk);
        check("final_idle", Busy, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
